// File: rtl/siso_prbs_checker_pkg.sv
// siso_prbs_checker_pkg: shared FSM states and PRBS7 (x^7+x^6+1) helpers for the chain checker
package siso_prbs_checker_pkg;
  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;
  localparam int PRBS_LEN = 7;
  localparam int TAP_A = 6;
  localparam int TAP_B = 5;
  function automatic logic prbs7_next(input logic [PRBS_LEN-1:0] lfsr);
    return lfsr[TAP_A] ^ lfsr[TAP_B];
  endfunction
endpackage

// File: rtl/siso_prbs_checker_sat_counter.sv
// sat_counter: counter that holds at all-ones; clr wins over inc
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic sat;
  assign sat = &q;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !sat) q <= q + 1'b1;
endmodule

// File: rtl/siso_prbs_checker.sv
// siso_prbs_checker: self-synchronising PRBS7 checker with lock FSM and saturating BER counters.
// Optional sticky loss-of-lock output LOL when PRBS_CHK_STICKY_LOL_EN is defined.
module siso_prbs_checker
  import siso_prbs_checker_pkg::*;
#(
  parameter int ERR_W      = 16,
  parameter int BIT_W      = 24,
  parameter int LOCK_CNT   = 32,
  parameter int WIN_LEN    = 64,
  parameter int UNLOCK_ERR = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             DIN,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [BIT_W-1:0] BIT_CNT
`ifdef PRBS_CHK_STICKY_LOL_EN
  ,
  output logic             LOL
`endif
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  state_t              state;
  logic [PRBS_LEN-1:0] lfsr;
  logic [2:0]          seed_cnt;
  logic [MW-1:0]       match_cnt;
  logic [WW-1:0]       win_cnt;
  logic [EW-1:0]       win_err;
  logic                pred, mis, chk, err, unlock;
  logic [PRBS_LEN-1:0] shifted;
  assign pred    = prbs7_next(lfsr);
  assign mis     = DIN != pred;
  assign chk     = EN && state == ST_LOCKED;
  assign err     = chk && mis;
  assign unlock  = err && win_err == EW'(UNLOCK_ERR - 1);
  assign shifted = {lfsr[PRBS_LEN-2:0], DIN};
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state     <= ST_HUNT;
      lfsr      <= '0;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      LOCKED    <= 1'b0;
      ERR_PULSE <= 1'b0;
    end else begin
      ERR_PULSE <= err;
      if (EN)
        case (state)
          ST_HUNT: begin
            lfsr <= shifted;
            if (seed_cnt == 3'(PRBS_LEN - 1)) begin
              seed_cnt <= '0;
              if (shifted != '0) begin
                state     <= ST_VERIFY;
                match_cnt <= '0;
              end
            end else seed_cnt <= seed_cnt + 1'b1;
          end
          ST_VERIFY: begin
            lfsr <= shifted;
            if (!mis) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == MW'(LOCK_CNT - 1)) begin
                state   <= ST_LOCKED;
                LOCKED  <= 1'b1;
                win_cnt <= '0;
                win_err <= '0;
              end
            end else begin
              state    <= ST_HUNT;
              seed_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            // free-running prediction keeps bit errors out of the reference
            lfsr    <= {lfsr[PRBS_LEN-2:0], pred};
            win_cnt <= win_cnt + 1'b1;
            if (unlock) begin
              state    <= ST_HUNT;
              LOCKED   <= 1'b0;
              seed_cnt <= '0;
            end else if (&win_cnt) win_err <= '0;
            else win_err <= win_err + EW'(mis);
          end
          default: state <= ST_HUNT;
        endcase
    end
`ifdef PRBS_CHK_STICKY_LOL_EN
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) LOL <= 1'b0;
    else LOL <= CLR_CNT ? 1'b0 : LOL | unlock;
`endif
  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk(CLK), .rst(RESET), .inc(err), .clr(CLR_CNT), .q(ERR_CNT)
  );
  sat_counter #(.W(BIT_W)) u_bit_cnt (
    .clk(CLK), .rst(RESET), .inc(chk), .clr(CLR_CNT), .q(BIT_CNT)
  );
endmodule

// File: tb/tb_siso_prbs_checker.sv
// tb_siso_prbs_checker: scoreboard bench for siso_prbs_checker (second instance with ERR_W=4)
module tb_siso_prbs_checker;
  logic        CLK = 1'b0, RESET = 1'b0, EN = 1'b0, DIN = 1'b0, CLR_CNT = 1'b0;
  logic        LOCKED, ERR_PULSE, LOCKED4, PULSE4;
  logic [15:0] ERR_CNT;
  logic [23:0] BIT_CNT, BCNT4;
  logic [3:0]  ECNT4;
  logic        lol, lol4;
  int          n_chk = 0, n_fail = 0, npulse = 0;
  logic [47:0] exp_q[$];
  logic [6:0]  g;
  int          fl[4];
  int          ms, mseed, mmatch, mwin, mwerr, me, me4, mb;
  logic [6:0]  ml;
  logic        mlock, mpulse, mlol;

  always #5 CLK = ~CLK;

  siso_prbs_checker dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIN(DIN), .CLR_CNT(CLR_CNT),
    .LOCKED(LOCKED), .ERR_PULSE(ERR_PULSE), .ERR_CNT(ERR_CNT), .BIT_CNT(BIT_CNT)
`ifdef PRBS_CHK_STICKY_LOL_EN
    , .LOL(lol)
`endif
  );
  siso_prbs_checker #(.ERR_W(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .DIN(DIN), .CLR_CNT(CLR_CNT),
    .LOCKED(LOCKED4), .ERR_PULSE(PULSE4), .ERR_CNT(ECNT4), .BIT_CNT(BCNT4)
`ifdef PRBS_CHK_STICKY_LOL_EN
    , .LOL(lol4)
`endif
  );
`ifndef PRBS_CHK_STICKY_LOL_EN
  assign lol = 1'b0;
  assign lol4 = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [47:0] dpk();
    return {lol, LOCKED, LOCKED4, ERR_PULSE, ECNT4, ERR_CNT, BIT_CNT};
  endfunction

  function automatic logic [47:0] mpk();
`ifdef PRBS_CHK_STICKY_LOL_EN
    return {mlol, mlock, mlock, mpulse, 4'(me4), 16'(me), 24'(mb)};
`else
    return {1'b0, mlock, mlock, mpulse, 4'(me4), 16'(me), 24'(mb)};
`endif
  endfunction

  task automatic mreset();
    ms = 0; mseed = 0; mmatch = 0; mwin = 0; mwerr = 0; me = 0; me4 = 0; mb = 0;
    ml = '0; mlock = 0; mpulse = 0; mlol = 0;
  endtask

  task automatic model(input logic en, input logic din, input logic clr);
    logic pr, mis;
    pr = ml[6] ^ ml[5];
    mis = din != pr;
    mpulse = 0;
    if (en) begin
      if (ms == 0) begin
        ml = {ml[5:0], din};
        if (mseed == 6) begin
          mseed = 0;
          if (ml != 0) begin ms = 1; mmatch = 0; end
        end else mseed++;
      end else if (ms == 1) begin
        ml = {ml[5:0], din};
        if (!mis) begin
          mmatch++;
          if (mmatch == 32) begin ms = 2; mlock = 1; mwin = 0; mwerr = 0; end
        end else begin ms = 0; mseed = 0; end
      end else begin
        ml = {ml[5:0], pr};
        mpulse = mis;
        if (mb < 24'hFFFFFF) mb++;
        if (mis && me < 65535) me++;
        if (mis && me4 < 15) me4++;
        mwerr += int'(mis);
        if (mwerr == 4) begin ms = 0; mlock = 0; mseed = 0; mlol = 1; end
        else if (mwin == 63) mwerr = 0;
        mwin = (mwin + 1) % 64;
      end
    end
    if (clr) begin me = 0; me4 = 0; mb = 0; mlol = 0; end
  endtask

  task automatic tick(input logic en, input logic din, input logic clr);
    EN = en; DIN = din; CLR_CNT = clr;
    model(en, din, clr);
    exp_q.push_back(mpk());
    @(posedge CLK);
    #1;
    if (ERR_PULSE) npulse++;
    check("cyc", 64'(dpk()), 64'(exp_q.pop_front()));
  endtask

  function automatic logic is_flip(input int i);
    foreach (fl[k]) if (fl[k] == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run(input int n, input logic clr = 1'b0);
    for (int i = 0; i < n; i++) begin
      logic b;
      b = g[6] ^ g[5];
      g = {g[5:0], b};
      tick(1'b1, b ^ is_flip(i), clr);
    end
    fl = '{-1, -1, -1, -1};
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #1;
    mreset();
    check("reset", 64'(dpk()), 64'(0));
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fl = '{-1, -1, -1, -1};
    g = 7'h7F;
    #2;
    do_reset();
    // clean stream: lock after exactly 39 enabled bits
    run(38);
    check("prelock", 64'(LOCKED), 64'(0));
    run(1);
    check("lock39", 64'(LOCKED), 64'(1));
    run(61);
    check("bit_cnt_n39", 64'(BIT_CNT), 64'(61));
    check("err_clean", 64'(ERR_CNT), 64'(0));
    run((64 - mwin) % 64);
    // three errors in one window stay locked
    npulse = 0;
    fl = '{10, 20, 30, -1};
    run(64);
    check("err3", 64'(ERR_CNT), 64'(3));
    check("pulses3", 64'(npulse), 64'(3));
    check("hold_lock", 64'(LOCKED), 64'(1));
    // window clear: three more in the next window still locked
    fl = '{8, 16, 24, -1};
    run(64);
    check("win_clear", 64'(LOCKED), 64'(1));
    check("err6", 64'(ERR_CNT), 64'(6));
    // fourth error in a window drops lock
    fl = '{5, 15, 25, -1};
    run(35);
    check("pre_unlock", 64'(LOCKED), 64'(1));
    fl = '{0, -1, -1, -1};
    run(1);
    check("unlock4", 64'(LOCKED), 64'(0));
    check("err10", 64'(ERR_CNT), 64'(10));
`ifdef PRBS_CHK_STICKY_LOL_EN
    check("lol_set", 64'(lol), 64'(1));
`endif
    run(38);
    check("relock_pre", 64'(LOCKED), 64'(0));
    run(1);
    check("relock", 64'(LOCKED), 64'(1));
    // unlock on the last bit of a window beats the window clear
    run(60);
    fl = '{0, 1, 2, 3};
    run(4);
    check("unlock_last", 64'(LOCKED), 64'(0));
    check("bit_keep", 64'(BIT_CNT), 64'(mb));
    run(39);
    check("relock2", 64'(LOCKED), 64'(1));
`ifdef PRBS_CHK_STICKY_LOL_EN
    check("lol_hold", 64'(lol), 64'(1));
`endif
    run(1, 1'b1);
    check("clr_bits", 64'(BIT_CNT), 64'(0));
`ifdef PRBS_CHK_STICKY_LOL_EN
    check("lol_clr", 64'(lol), 64'(0));
`endif
    // async reset mid-lock, then alternate EN
    do_reset();
    g = 7'h7F;
    for (int i = 0; i < 77; i++) begin
      if (i % 2 == 0) begin
        logic b;
        b = g[6] ^ g[5];
        g = {g[5:0], b};
        tick(1'b1, b, 1'b0);
      end else tick(1'b0, 1'($urandom_range(1)), 1'b0);
      if (i == 75) check("en_prelock", 64'(LOCKED), 64'(0));
      if (i == 76) check("en_lock77", 64'(LOCKED), 64'(1));
    end
    // stuck-at-0 chain never locks
    do_reset();
    begin
      int nl = 0;
      for (int i = 0; i < 200; i++) begin
        tick(1'b1, 1'b0, 1'b0);
        if (LOCKED) nl++;
      end
      check("stuck0_lock", 64'(nl), 64'(0));
      check("stuck0_err", 64'(ERR_CNT), 64'(0));
    end
    // saturation on the 4-bit instance, then clear beats a coincident error
    do_reset();
    g = 7'h7F;
    run(39);
    for (int w = 0; w < 7; w++) begin
      fl = (w == 6) ? '{10, 30, -1, -1} : '{10, 30, 50, -1};
      run(64);
    end
    check("sat_lock", 64'(LOCKED), 64'(1));
    check("err20", 64'(ERR_CNT), 64'(20));
    check("sat15", 64'(ECNT4), 64'(15));
    fl = '{0, -1, -1, -1};
    run(1, 1'b1);
    check("clr_err", 64'(ERR_CNT), 64'(0));
    check("clr_err4", 64'(ECNT4), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/siso_prbs_checker.md
Name: siso_prbs_checker

Overview:
- Serial consumer sitting directly downstream of the last reset-flop stage of the SISO shift-register chain under test.
- Takes one bit per enabled clock from the chain output and self-synchronises to a PRBS7 stream (x^7+x^6+1).
- Declares lock, then counts bit errors for on-chip readout.
- Together with the upstream PRBS7 source, it gives a pass/fail and BER figure per chain.

Parameters:
- ERR_W, 16, width of the saturating error counter.
- BIT_W, 24, width of the saturating checked-bit counter.
- LOCK_CNT, 32, consecutive correct predictions needed in VERIFY to enter LOCKED.
- WIN_LEN, 64, error-window length in checked bits (power of two).
- UNLOCK_ERR, 4, errors within one window that force loss of lock.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous reset, active-high.
- EN  input  1  bit-valid strobe; DIN is sampled only when EN=1.
- DIN  input  1  serial data from the end of the SISO chain.
- CLR_CNT  input  1  synchronous clear of ERR_CNT and BIT_CNT.
- LOCKED  output  1  1 while the FSM is in LOCKED.
- ERR_PULSE  output  1  one-cycle pulse on each counted mismatch.
- ERR_CNT  output  ERR_W  saturating mismatch count while LOCKED.
- BIT_CNT  output  BIT_W  saturating count of bits checked while LOCKED.

Behaviour:
- Clock and reset: one clock domain, CLK. RESET is asynchronous, active-high, and overrides everything.
- Reset values: state=HUNT, lfsr=7'h00, seed_cnt=0, match_cnt=0, win_cnt=0, win_err=0, LOCKED=0, ERR_PULSE=0, ERR_CNT=0, BIT_CNT=0.
- Registered outputs: all outputs are registered. Nothing changes on a cycle with EN=0, except the CLR_CNT effect and ERR_PULSE returning to 0.
- Prediction: pred = lfsr[6]^lfsr[5]. The register shifts left with the new bit into lfsr[0].
- HUNT:
  - Shift DIN into lfsr; seed_cnt increments.
  - After 7 bits, go to VERIFY with match_cnt=0.
  - If the 7 seeded bits are all zero (stuck-at-0 chain), stay in HUNT and restart seed_cnt.
- VERIFY:
  - Shift DIN into lfsr (self-synchronising).
  - If DIN==pred, match_cnt++. On reaching LOCK_CNT, go to LOCKED next cycle.
  - If DIN!=pred, return to HUNT with seed_cnt=0.
  - No counters update in this state.
- LOCKED:
  - Shift pred (not DIN) into lfsr, so errors do not propagate into the prediction.
  - BIT_CNT++ per checked bit.
  - If DIN!=pred: ERR_CNT++, ERR_PULSE=1 for one cycle, win_err++.
  - win_cnt wraps at WIN_LEN; win_err clears on wrap.
  - If win_err reaches UNLOCK_ERR inside one window, go to HUNT with LOCKED=0 on the next cycle. ERR_CNT and BIT_CNT are retained.
- Saturation: ERR_CNT and BIT_CNT stop at all-ones and never wrap.
- CLR_CNT:
  - Clears both counters on the next edge and has priority over an increment in the same cycle.
  - Does not affect the FSM or lfsr.
- Unlock on a final error: if the error that reaches UNLOCK_ERR coincides with the last bit of the window, unlock takes priority over the window clear.
- Reset mid-operation: immediate return to the reset values; there is no partial-lock retention.
- Latency: the DIN sample to ERR_PULSE/ERR_CNT update is 1 cycle. Minimum time to lock is 7+LOCK_CNT enabled bits.

Optional Feature:
- Macro: PRBS_CHK_STICKY_LOL_EN.
- When defined:
  - Adds output LOL (1 bit, reset 0).
  - LOL is set on any LOCKED->HUNT transition and stays set until CLR_CNT or RESET.
  - It survives relock.
- When undefined: the LOL port and its register do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state enum (HUNT, VERIFY, LOCKED);
  - PRBS7 constants: length 7, tap indices 6 and 5;
  - a function prbs7_next(lfsr) returning pred.
- One natural sub-module, sat_counter (parameterised width, inc, clr, sat). It is instantiated twice, for ERR_CNT and BIT_CNT.

Test Plan:
- Clean PRBS7 seeded 7'h7F, EN=1 every cycle → LOCKED=1 after exactly 39 enabled bits; ERR_CNT=0; BIT_CNT=N-39 after N bits.
- Lock first, then flip 3 bits spaced more than 7 apart within one 64-bit window → ERR_CNT=3, three single-cycle ERR_PULSEs, LOCKED stays 1.
- Lock first, then flip 4 bits within one window → LOCKED falls 1 cycle after the 4th error; ERR_CNT=4; relock after a further 39 clean bits.
- DIN held 0 for 200 bits → LOCKED=0 throughout, FSM never leaves HUNT, ERR_CNT=0.
- EN toggled 1/0 on alternate cycles with a clean stream → lock after 39 enabled bits (77 cycles); no state change on EN=0 cycles.
- ERR_W=4, 20 isolated errors spread over windows → ERR_CNT saturates at 15. CLR_CNT asserted together with an error → ERR_CNT=0. With PRBS_CHK_STICKY_LOL_EN, a forced unlock sets LOL=1, it holds through relock, and CLR_CNT clears it.
